// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp on a 32-bit slave bus, registered timer IRQ.
// Define CLINT_MSIP_EN to build the MSIP register and the soft_irq_o output.
module clint_timer #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_en_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        timer_irq_o
`ifdef CLINT_MSIP_EN
    ,
    output logic        soft_irq_o
`endif
);

    localparam logic [15:0] TickMax = 16'(TICK_DIV - 1);

    // Word offsets (byte offset >> 2) relative to BASE_ADDR
    localparam logic [13:0] AddrMsip    = 14'h0000;
    localparam logic [13:0] AddrCmpLo   = 14'h1000;
    localparam logic [13:0] AddrCmpHi   = 14'h1001;
    localparam logic [13:0] AddrMtimeLo = 14'h2FFE;
    localparam logic [13:0] AddrMtimeHi = 14'h2FFF;

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q;
    logic        irq_q;

    logic [13:0] word;
    logic        wr, rd, tick, carry;
    logic [31:0] lo_inc, hi_inc, rmux;
    logic        unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign word        = addr_i[15:2] - BASE_ADDR[15:2];
    assign wr          = req_i & we_i;
    assign rd          = req_i & ~we_i;

`ifdef CLINT_MSIP_EN
    logic msip_q, msip_d;

    always_comb begin
        msip_d = msip_q;
        if (wr && word == AddrMsip) begin
            msip_d = wdata_i[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
        end
    end

    assign soft_irq_o = msip_q;
`endif

    always_comb begin
        tick    = timer_en_i && (presc_q == TickMax);
        presc_d = presc_q;
        if (timer_en_i) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end

        // Increment first, then let a same-cycle bus write override the written half only
        {carry, lo_inc} = {1'b0, mtime_q[31:0]} + {32'd0, tick};
        hi_inc          = mtime_q[63:32] + {31'd0, carry};
        mtime_d         = {hi_inc, lo_inc};
        if (wr && word == AddrMtimeLo) begin
            mtime_d[31:0] = wdata_i;
        end
        if (wr && word == AddrMtimeHi) begin
            mtime_d[63:32] = wdata_i;
        end

        cmp_d = cmp_q;
        if (wr && word == AddrCmpLo) begin
            cmp_d[31:0] = wdata_i;
        end
        if (wr && word == AddrCmpHi) begin
            cmp_d[63:32] = wdata_i;
        end

        rmux = 32'd0;
        unique case (word)
`ifdef CLINT_MSIP_EN
            AddrMsip:    rmux = {31'd0, msip_q};
`endif
            AddrCmpLo:   rmux = cmp_q[31:0];
            AddrCmpHi:   rmux = cmp_q[63:32];
            AddrMtimeLo: rmux = mtime_q[31:0];
            AddrMtimeHi: rmux = mtime_q[63:32];
            default:     rmux = 32'd0;
        endcase
        rdata_d = rd ? rmux : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            rdata_q <= rdata_d;
            ack_q   <= req_i;
            irq_q   <= (mtime_q >= cmp_q);
        end
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: vector table plus hand-written timing sequences.
// Two instances share the bus: dut1 (TICK_DIV=1) and dut4 (TICK_DIV=4).
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst, en, req, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata4;
    logic        ack1, ack4, irq1, irq4;
`ifdef CLINT_MSIP_EN
    logic        soft1, soft4;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] r1, r4;

    always #5 clk = ~clk;

    clint_timer #(.TICK_DIV(1), .BASE_ADDR(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .timer_en_i(en), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata1), .ack_o(ack1), .timer_irq_o(irq1)
`ifdef CLINT_MSIP_EN
        , .soft_irq_o(soft1)
`endif
    );

    clint_timer #(.TICK_DIV(4), .BASE_ADDR(16'h0000)) dut4 (
        .clk(clk), .rst(rst), .timer_en_i(en), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata4), .ack_o(ack4), .timer_irq_o(irq4)
`ifdef CLINT_MSIP_EN
        , .soft_irq_o(soft4)
`endif
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One request cycle; returns the data acked by each instance
    task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                       output logic [31:0] o1, output logic [31:0] o4);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        step(1);
        req   = 1'b0;
        we    = 1'b0;
        check("ack", 64'(ack1), 64'd1);
        o1 = rdata1;
        o4 = rdata4;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'hBFF8, 32'h0,        32'h0000_000A};
        tbl[1]  = '{1'b0, 16'hBFFC, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 16'h4000, 32'h0,        32'hFFFF_FFFF};
        tbl[3]  = '{1'b0, 16'h4004, 32'h0,        32'hFFFF_FFFF};
        tbl[4]  = '{1'b0, 16'h0000, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 16'h1234, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 16'h4000, 32'h55,       32'h0};
        tbl[7]  = '{1'b0, 16'h4000, 32'h0,        32'h55};
        tbl[8]  = '{1'b1, 16'hBFFC, 32'h12345678, 32'h0};
        tbl[9]  = '{1'b0, 16'hBFFC, 32'h0,        32'h12345678};
        tbl[10] = '{1'b1, 16'h2000, 32'hDEADBEEF, 32'h0};
        tbl[11] = '{1'b0, 16'h2000, 32'h0,        32'h0};
        tbl[12] = '{1'b1, 16'hBFFC, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 16'h4000, 32'hFFFF_FFFF, 32'h0};
        tbl[14] = '{1'b0, 16'hBFF8, 32'h0,        32'h0000_000A};

        rst = 1'b1; en = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 32'h0;
        step(3);
        check("rst_ack", 64'(ack1), 64'd0);
        check("rst_rdata", 64'(rdata1), 64'd0);
        check("rst_irq", 64'(irq1), 64'd0);

        // Ten enabled cycles at TICK_DIV=1
        rst = 1'b0;
        en  = 1'b1;
        step(10);
        en  = 1'b0;
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("count10", 64'(r1), 64'hA);
        check("irq_low", 64'(irq1), 64'd0);

        for (int i = 0; i < 15; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, r1, r4);
            check($sformatf("vec%0d", i), 64'(r1), 64'(tbl[i].exp));
            check($sformatf("vec%0d_irq", i), 64'(irq1), 64'd0);
        end
        step(1);
        check("ack_pulse", 64'(ack1), 64'd0);
        check("rdata_idle", 64'(rdata1), 64'd0);

        // Compare match: irq follows mtime reaching mtimecmp by one cycle
        bus(1'b1, 16'hBFF8, 32'h1E, r1, r4);
        bus(1'b1, 16'h4004, 32'h0, r1, r4);
        bus(1'b1, 16'h4000, 32'h20, r1, r4);
        check("irq_before", 64'(irq1), 64'd0);
        en = 1'b1;
        step(2);
        en = 1'b0;
        check("irq_at_match", 64'(irq1), 64'd0);
        step(1);
        check("irq_rise", 64'(irq1), 64'd1);
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("mtime_match", 64'(r1), 64'h20);
        bus(1'b1, 16'h4004, 32'hFFFF_FFFF, r1, r4);
        check("irq_hold", 64'(irq1), 64'd1);
        step(1);
        check("irq_fall", 64'(irq1), 64'd0);

        // LO->HI carry on a tick
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, r1, r4);
        bus(1'b1, 16'hBFFC, 32'h0, r1, r4);
        en = 1'b1;
        step(1);
        en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("carry_lo", 64'(r1), 64'h0);
        bus(1'b0, 16'hBFFC, 32'h0, r1, r4);
        check("carry_hi", 64'(r1), 64'h1);

        // HI write during a carrying tick discards the carry
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, r1, r4);
        en = 1'b1;
        bus(1'b1, 16'hBFFC, 32'h5, r1, r4);
        en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("hiwr_lo", 64'(r1), 64'h0);
        bus(1'b0, 16'hBFFC, 32'h0, r1, r4);
        check("hiwr_hi", 64'(r1), 64'h5);

        // LO write during a carrying tick still carries into HI
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, r1, r4);
        en = 1'b1;
        bus(1'b1, 16'hBFF8, 32'h7, r1, r4);
        en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("lowr_lo", 64'(r1), 64'h7);
        bus(1'b0, 16'hBFFC, 32'h0, r1, r4);
        check("lowr_hi", 64'(r1), 64'h6);

        // Back-to-back reads
        req = 1'b1; we = 1'b0; addr = 16'hBFF8;
        step(1);
        addr = 16'hBFFC;
        check("b2b_ack0", 64'(ack1), 64'd1);
        check("b2b_lo", 64'(rdata1), 64'h7);
        step(1);
        req = 1'b0;
        check("b2b_ack1", 64'(ack1), 64'd1);
        check("b2b_hi", 64'(rdata1), 64'h6);
        step(1);
        check("b2b_end", 64'(ack1), 64'd0);

        // Reset coinciding with a request drops the ack
        req = 1'b1; we = 1'b0; addr = 16'hBFF8; rst = 1'b1;
        step(1);
        req = 1'b0;
        check("rst_drop_ack", 64'(ack1), 64'd0);
        check("rst_drop_rdata", 64'(rdata1), 64'd0);
        rst = 1'b0;
        bus(1'b0, 16'h4004, 32'h0, r1, r4);
        check("rst_cmp", 64'(r1), 64'hFFFF_FFFF);
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("rst_mtime", 64'(r1), 64'h0);

        // Prescaler at TICK_DIV=4, then frozen by timer_en_i
        en = 1'b1;
        step(40);
        en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("div4_count", 64'(r4), 64'hA);
        check("div1_count", 64'(r1), 64'h28);
        step(20);
        bus(1'b0, 16'hBFF8, 32'h0, r1, r4);
        check("div4_frozen", 64'(r4), 64'hA);

`ifdef CLINT_MSIP_EN
        bus(1'b1, 16'h0000, 32'h1, r1, r4);
        check("soft_set", 64'(soft1), 64'd1);
        bus(1'b0, 16'h0000, 32'h0, r1, r4);
        check("msip_read", 64'(r1), 64'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("soft_rst", 64'(soft1), 64'd0);
        bus(1'b0, 16'h4004, 32'h0, r1, r4);
        check("msip_rst_cmp", 64'(r1), 64'hFFFF_FFFF);
`else
        bus(1'b1, 16'h0000, 32'h1, r1, r4);
        bus(1'b0, 16'h0000, 32'h0, r1, r4);
        check("msip_absent", 64'(r1), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
